// File: rtl/axis_gpio_writer.sv
// axis_gpio_writer: paced AXI4-Stream to GPIO pattern driver.
// Each accepted word carries {output-enable mask, pin values}. The word stays
// on the pads for max(cfg_data,1) cycles. The next word can only be accepted
// once that hold period has run out. sts_data counts stream underruns, i.e.
// HOLD->IDLE transitions.

// One bidirectional pad. The input path is not used by this block, so it is not
// modelled here.
module gpio_iobuf (
  input  logic i,
  input  logic t,
  inout  wire  io
);
  assign io = t ? 1'bz : i;
endmodule

module axis_gpio_writer #(
  parameter int GPIO_DATA_WIDTH  = 8,
  parameter int AXIS_TDATA_WIDTH = 16,  // must be 2*GPIO_DATA_WIDTH
  parameter int CNTR_WIDTH       = 32
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [CNTR_WIDTH-1:0]       cfg_data,
  inout  wire  [GPIO_DATA_WIDTH-1:0]  gpio_data,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic [31:0]                 sts_data
);

  localparam int GW = GPIO_DATA_WIDTH;

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  // Stream word layout: the upper half holds the enables and the lower half holds the pin values.
  typedef struct packed {
    logic [GW-1:0] oe;
    logic [GW-1:0] data;
  } word_t;

  state_t                int_state_reg;
  logic [GW-1:0]         int_data_reg;
  logic [GW-1:0]         int_oe_reg;
  logic [CNTR_WIDTH-1:0] int_cntr_reg;
  logic [31:0]           int_gap_reg;

  word_t                 s_word;
  logic [CNTR_WIDTH-1:0] hold_len;
  logic                  cntr_last;
  logic                  handshake;

  assign s_word    = s_axis_tdata;
  // A hold period of 0 would stall the counter, so it is clamped to 1.
  assign hold_len  = (cfg_data == '0) ? CNTR_WIDTH'(1) : cfg_data;
  assign cntr_last = (int_cntr_reg == CNTR_WIDTH'(1));

  // Ready is derived only from registered state. It is high when idle or during the final hold cycle,
  // so a waiting word is taken back-to-back with no gap cycle.
  assign s_axis_tready = (int_state_reg == IDLE) | cntr_last;
  assign handshake     = s_axis_tvalid & s_axis_tready;
  assign sts_data      = int_gap_reg;

  // Hold FSM: load on a handshake, count the hold period down, and drop to IDLE when the stream underruns.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      int_state_reg <= IDLE;
      int_data_reg  <= '0;
      int_oe_reg    <= '0;
      int_cntr_reg  <= '0;
      int_gap_reg   <= '0;
    end else if (handshake) begin
      // cfg_data is sampled only here, so a change during a hold applies to the next word.
      int_state_reg <= HOLD;
      int_data_reg  <= s_word.data;
      int_oe_reg    <= s_word.oe;
      int_cntr_reg  <= hold_len;
    end else if (int_state_reg == HOLD) begin
      if (!cntr_last) begin
        int_cntr_reg <= int_cntr_reg - CNTR_WIDTH'(1);
      end else begin
        // The hold period has expired and no word is waiting. The pins keep the last
        // word, and this underrun counts as one gap.
        int_state_reg <= IDLE;
        int_gap_reg   <= int_gap_reg + 32'd1;
      end
    end
  end

  // One pad per pin. T is active-high tristate, so it is the inverted enable.
  for (genvar j = 0; j < GW; j++) begin : g_pin
    gpio_iobuf u_iobuf (
      .i  (int_data_reg[j]),
      .t  (~int_oe_reg[j]),
      .io (gpio_data[j])
    );
  end

endmodule

// File: doc/axis_gpio_writer.md
# axis_gpio_writer

Drives a bank of bidirectional GPIO pins from an AXI4-Stream slave port, and is the output counterpart of the stream-side GPIO reader. Each accepted stream word carries a pin value and a per-pin output-enable mask. The word is held on the pins for a programmable number of clock cycles before the next word is accepted. It sits between a DMA/FIFO stream source and the board I/O, for paced pattern generation on GPIO headers.

## Interface
- GPIO_DATA_WIDTH, 8: number of GPIO pins.
- AXIS_TDATA_WIDTH, 16: stream word width; must equal 2*GPIO_DATA_WIDTH.
- CNTR_WIDTH, 32: width of the hold-period counter and of cfg_data.

- aclk  input  1  clock; all logic on rising edge.
- aresetn  input  1  asynchronous, active-low reset.
- cfg_data  input  CNTR_WIDTH  hold period in aclk cycles per word; 0 is treated as 1.
- gpio_data  inout  GPIO_DATA_WIDTH  pads; one IOBUF per bit.
- s_axis_tdata  input  AXIS_TDATA_WIDTH  bits [GPIO_DATA_WIDTH-1:0] are the pin values; bits [2*GPIO_DATA_WIDTH-1:GPIO_DATA_WIDTH] are the output enables (1 = drive).
- s_axis_tvalid  input  1  stream valid.
- s_axis_tready  output  1  stream ready.
- sts_data  output  32  count of stream gaps (HOLD→IDLE transitions), wraps at 2^32.

## Operation
- Registers:
  - int_data_reg, int_oe_reg: GPIO_DATA_WIDTH each.
  - int_cntr_reg: CNTR_WIDTH.
  - int_state_reg: IDLE/HOLD.
  - int_gap_reg: 32 bits.
- Per bit j, the IOBUF connects as follows: I = int_data_reg[j], T = ~int_oe_reg[j], O unused.
- s_axis_tready is combinational: 1 when state is IDLE, or when state is HOLD and int_cntr_reg == 1.
- A handshake is s_axis_tvalid & s_axis_tready. On a handshake, at the next edge:
  - int_data_reg and int_oe_reg load from tdata.
  - int_cntr_reg loads max(cfg_data, 1).
  - state becomes HOLD.
- cfg_data is sampled only at handshake edges. Changes mid-hold take effect from the next word.
- IDLE: no handshake → state unchanged. The pins keep the last data and enables.
- HOLD, int_cntr_reg > 1: the counter decrements by 1. tready = 0.
- HOLD, int_cntr_reg == 1:
  - With tvalid: reload as above and stay in HOLD, giving back-to-back words with no gap cycle.
  - Without tvalid: go to IDLE, int_gap_reg += 1, and the pins keep their last value.
- With cfg_data ≤ 1 and tvalid held high, one word is accepted every cycle.
- The end of a stream counts as one gap, by definition.
- The counter never underflows; in HOLD it is always ≥ 1.
- Reset (asynchronous assert, release synchronous to aclk by the system):
  - state IDLE, int_cntr_reg 0.
  - int_data_reg 0, int_oe_reg 0, so all pins are tristated.
  - sts_data 0. s_axis_tready = 1 from the first cycle after release.
- Reset mid-hold aborts the word immediately. Pins tristate asynchronously, and the word in flight is lost.

## Timing
- Latency: word accepted at edge k → driven onto the IOBUF I/T from just after edge k.
- Each word is visible for exactly max(cfg_data,1) cycles when the next word is ready in time.
- s_axis_tready depends only on registered state, with no combinational path from tvalid.
- sts_data updates on the edge of the HOLD→IDLE transition.
- Output enables and data change on the same edge; there is no separate enable sequencing.

## Test plan
- Reset: assert aresetn=0 mid-hold.
  - Required: pins Z immediately, sts_data=0, tready=1 after release, no stale word is driven.
- Paced stream: cfg_data=4, tvalid held 1, words 0xFF01, 0xFF02, 0xFF03.
  - Required: pins show 0x01, 0x02, 0x03 for 4 cycles each with no gaps.
  - Required: tready pulses 1 every 4th cycle. sts_data=1 after the last word.
- Full rate: cfg_data=0 then 1, 8 consecutive words.
  - Required: one word per cycle, pin value changes every cycle, tready constantly 1.
- Partial enable: word 0x0FA5 (oe=0x0F, data=0xA5).
  - Required: pins[3:0]=0x5 driven, pins[7:4]=Z.
- Underrun and resume: cfg_data=3, two words, 5 idle cycles, one more word.
  - Required: the second value persists through the gap, sts_data=2 at the end.
  - Required: the third word appears the cycle after its handshake.
- cfg change mid-hold: cfg_data 5→2 during word A.
  - Required: A holds 5 cycles, the following word B holds 2.
